mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage, upstream of writeback.
- Registers the execute-stage result, dest index, control and write enable.
- LOAD/STORE run on a single-port data memory through a req/ack handshake; upstream is stalled until the access completes or times out.
- All other ops pass through to writeback with one cycle of latency.

Parameters:
- DATA_W, 16, data and address width.
- MEM_TIMEOUT, 15, max ACCESS cycles without mem_ack before abort (>=2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute-stage outputs are valid this cycle.
- control_in  in  5  control from execute. [3:0] is the opcode; [4] passes through.
- result_in  in  DATA_W  ALU result. This is the address for LOAD/STORE.
- store_data_in  in  DATA_W  store data (execute reg1_data) for STORE.
- dest_index_in  in  6  destination register index.
- write_enable_in  in  1  register write enable from execute.
- stall_out  out  1  high while an access is in flight; execute must hold its outputs.
- mem_req  out  1  data-memory request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack is high.
- mem_ack  in  1  memory completion, sampled on a clk edge.
- wb_valid  out  1  one-cycle pulse: writeback outputs are new.
- wb_data  out  DATA_W  result or load data.
- wb_dest_index  out  6  destination index.
- wb_write_enable  out  1  register-file write enable.
- wb_control  out  5  control forwarded to writeback.
- mem_error  out  1  sticky timeout flag.

Behaviour:
- Opcodes: LOAD = 4'b1100, STORE = 4'b1110, NOP = 4'b0000; any other opcode is non-memory.
- Reset (rst_n low, asynchronous): state IDLE, timeout counter 0. All outputs 0: stall_out, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_data, wb_dest_index, wb_write_enable, wb_control, mem_error.
- State IDLE:
  - ex_valid low, or NOP → nothing captured; wb_valid 0 next cycle.
  - Non-memory op at edge N → after edge N: wb_valid=1, wb_data=result_in, wb_dest_index=dest_index_in, wb_write_enable=write_enable_in, wb_control=control_in. Latency 1.
  - LOAD/STORE at edge N → move to ACCESS. Register mem_req=1, mem_addr=result_in, mem_we=(STORE), mem_wdata=store_data_in (0 for LOAD); capture dest/control; counter=0; stall_out=1 after edge N.
- State ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until completion.
  - ex_valid is ignored (execute is stalled).
  - Counter increments every edge without ack.
  - mem_ack high at an edge → mem_req=0, stall_out=0, return to IDLE, wb_valid=1 for one cycle.
    - LOAD: wb_data=mem_rdata, wb_write_enable=1.
    - STORE: wb_data=mem_addr, wb_write_enable=0.
    - Minimum LOAD/STORE latency is 2 edges (ack in the first ACCESS cycle).
  - Counter reaches MEM_TIMEOUT-1 with no ack at that edge → abort: mem_req=0, stall_out=0, mem_error=1, wb_valid=1, wb_write_enable=0, return to IDLE.
  - Ack and timeout on the same edge: ack wins, no error.
- wb_valid is a single-cycle pulse. wb_data, wb_dest_index, wb_write_enable and wb_control hold their values until the next wb_valid.
- wb_write_enable is forced to 0 in any cycle where wb_valid is 0.
- mem_ack while IDLE is ignored.
- stall_out is registered and equals (state==ACCESS).
- mem_error clears only on reset.
- Reset asserted mid-ACCESS: mem_req and stall_out drop immediately (asynchronous) and the access is discarded; no wb_valid.
- No arithmetic in this stage; widths pass through unchanged.

Test Plan:
- ADD passthrough: ex_valid=1, control=5'b00010, result_in=16'h0042, dest=6'd3, we=1 → next cycle wb_valid=1, wb_data=16'h0042, wb_dest_index=3, wb_write_enable=1; stall_out stays 0.
- LOAD, ack after 3 cycles: opcode 1100, result_in=16'h0010, mem_rdata=16'hBEEF → mem_req=1 with addr 16'h0010 and we=0 for 3 cycles; stall_out=1 throughout; then wb_valid=1, wb_data=16'hBEEF, wb_write_enable=1, mem_req=0.
- STORE, immediate ack: opcode 1110, result_in=16'h0020, store_data_in=16'h1234, mem_ack held high → mem_req=1, we=1, wdata=16'h1234 for 1 cycle; next cycle wb_valid=1, wb_write_enable=0.
- Timeout: LOAD with mem_ack held 0 and MEM_TIMEOUT=15 → mem_req high for exactly 15 cycles, then mem_error=1, wb_valid pulse with wb_write_enable=0; mem_error stays 1 through later ops.
- Stall ordering: LOAD followed by SUB held on ex_valid during ACCESS → SUB is not captured until stall_out=0; writeback order is LOAD then SUB, each with one wb_valid pulse.
- Reset mid-access: drive rst_n=0 during the 2nd ACCESS cycle → mem_req, stall_out and all wb outputs go to 0 immediately; after release the stage is IDLE and a later mem_ack produces no wb_valid.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: forwards execute results to writeback and runs
// LOAD/STORE on a single-port data memory through a req/ack handshake with timeout.
module mem_stage #(
   parameter int DATA_W      = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic [4:0]        control_in,
   input  logic [DATA_W-1:0] result_in,
   input  logic [DATA_W-1:0] store_data_in,
   input  logic [5:0]        dest_index_in,
   input  logic              write_enable_in,
   output logic              stall_out,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              wb_valid,
   output logic [DATA_W-1:0] wb_data,
   output logic [5:0]        wb_dest_index,
   output logic              wb_write_enable,
   output logic [4:0]        wb_control,
   output logic              mem_error
);

   localparam logic [3:0] OP_LOAD  = 4'b1100;
   localparam logic [3:0] OP_STORE = 4'b1110;
   localparam logic [3:0] OP_NOP   = 4'b0000;
   localparam int         CNT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [5:0]       dest_p1;
   logic [4:0]       ctrl_p1;
   logic [3:0]       opcode;
   logic             is_mem;
   logic             is_store;

   assign opcode   = control_in[3:0];
   assign is_store = (opcode == OP_STORE);
   assign is_mem   = (opcode == OP_LOAD) || is_store;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         cnt             <= '0;
         dest_p1         <= '0;
         ctrl_p1         <= '0;
         stall_out       <= 1'b0;
         mem_req         <= 1'b0;
         mem_we          <= 1'b0;
         mem_addr        <= '0;
         mem_wdata       <= '0;
         wb_valid        <= 1'b0;
         wb_data         <= '0;
         wb_dest_index   <= '0;
         wb_write_enable <= 1'b0;
         wb_control      <= '0;
         mem_error       <= 1'b0;
      end else begin
         // Pulse-type outputs default low; write enable never outlives its pulse.
         wb_valid        <= 1'b0;
         wb_write_enable <= 1'b0;
         if (state == IDLE) begin
            if (ex_valid && (opcode != OP_NOP)) begin
               if (is_mem) begin
                  state     <= ACCESS;
                  stall_out <= 1'b1;
                  mem_req   <= 1'b1;
                  mem_we    <= is_store;
                  mem_addr  <= result_in;
                  mem_wdata <= is_store ? store_data_in : '0;
                  dest_p1   <= dest_index_in;
                  ctrl_p1   <= control_in;
                  cnt       <= '0;
               end else begin
                  wb_valid        <= 1'b1;
                  wb_data         <= result_in;
                  wb_dest_index   <= dest_index_in;
                  wb_write_enable <= write_enable_in;
                  wb_control      <= control_in;
               end
            end
         end else begin
            // Ack is checked first so that ack on the timeout edge still completes.
            if (mem_ack) begin
               state           <= IDLE;
               stall_out       <= 1'b0;
               mem_req         <= 1'b0;
               wb_valid        <= 1'b1;
               wb_dest_index   <= dest_p1;
               wb_control      <= ctrl_p1;
               wb_write_enable <= !mem_we;
               wb_data         <= mem_we ? mem_addr : mem_rdata;
            end else if (cnt == CNT_LAST) begin
               state         <= IDLE;
               stall_out     <= 1'b0;
               mem_req       <= 1'b0;
               mem_error     <= 1'b1;
               wb_valid      <= 1'b1;
               wb_dest_index <= dest_p1;
               wb_control    <= ctrl_p1;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule
